// File: rtl/dfc_vc_receiver.sv
// Multi-channel delayed-flow-control link receiver: one shared vld/data link demultiplexed into
// per-channel FIFOs, each with its own registered flow control and srdy/drdy output.
module dfc_vc_receiver #(
  parameter int unsigned width     = 8,
  parameter int unsigned depth     = 8,
  parameter int unsigned channels  = 2,
  parameter int unsigned threshold = 2
) (
  input  logic                                              clk,
  input  logic                                              reset_n,
  input  logic                                              c_vld,
  input  logic [((channels > 1) ? $clog2(channels) : 1)-1:0] c_vc,
  input  logic [width-1:0]                                  c_data,
  output logic [channels-1:0]                               c_fc_n,
  output logic [channels-1:0]                               p_srdy,
  input  logic [channels-1:0]                               p_drdy,
  output logic [channels*width-1:0]                         p_data,
  output logic [channels-1:0]                               ovf
);

  localparam int unsigned VcW  = (channels > 1) ? $clog2(channels) : 1;
  localparam int unsigned PtrW = (depth > 1) ? $clog2(depth) : 1;
  localparam int unsigned CntW = $clog2(depth + 1);

  localparam logic [CntW-1:0] DepthCnt = CntW'(depth);
  localparam logic [CntW-1:0] ThrCnt   = CntW'(threshold);

  logic [width-1:0]                mem_q [channels][depth];
  logic [PtrW-1:0]                 rd_ptr_q [channels];
  logic [PtrW-1:0]                 rd_ptr_d [channels];
  logic [PtrW-1:0]                 wr_ptr_q [channels];
  logic [PtrW-1:0]                 wr_ptr_d [channels];
  logic [CntW-1:0]                 cnt_q [channels];
  logic [CntW-1:0]                 cnt_d [channels];
  logic [CntW-1:0]                 remain [channels];
  logic [channels-1:0][width-1:0]  head_q;
  logic [channels-1:0][width-1:0]  head_d;
  logic [channels-1:0]             srdy_q;
  logic [channels-1:0]             srdy_d;
  logic [channels-1:0]             fc_n_q;
  logic [channels-1:0]             fc_n_d;
  logic [channels-1:0]             ovf_q;
  logic [channels-1:0]             ovf_d;
  logic [channels-1:0]             hit;
  logic [channels-1:0]             full;
  logic [channels-1:0]             push;
  logic [channels-1:0]             pop;

  always_comb begin
    for (int i = 0; i < channels; i++) begin
      pop[i]  = srdy_q[i] & p_drdy[i];
      hit[i]  = c_vld && (c_vc == VcW'(i));
      full[i] = (cnt_q[i] == DepthCnt);
      // A full channel still accepts a beat when its head leaves on the same edge.
      push[i] = hit[i] && (!full[i] || pop[i]);
      ovf_d[i] = ovf_q[i] | (hit[i] & full[i] & ~pop[i]);

      cnt_d[i]    = cnt_q[i] + CntW'(push[i]) - CntW'(pop[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + PtrW'(pop[i]);
      wr_ptr_d[i] = wr_ptr_q[i] + PtrW'(push[i]);
      remain[i]   = cnt_q[i] - CntW'(pop[i]);

      // Next head: the arriving beat if nothing else remains, otherwise the stored entry.
      head_d[i] = head_q[i];
      if (cnt_d[i] != '0) begin
        if (remain[i] == '0) begin
          head_d[i] = c_data;
        end else begin
          head_d[i] = mem_q[i][rd_ptr_d[i]];
        end
      end

      srdy_d[i] = (cnt_d[i] != '0);
      fc_n_d[i] = ((DepthCnt - cnt_d[i]) > ThrCnt);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < channels; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      head_q <= '0;
      srdy_q <= '0;
      fc_n_q <= '1;
      ovf_q  <= '0;
    end else begin
      for (int i = 0; i < channels; i++) begin
        rd_ptr_q[i] <= rd_ptr_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      head_q <= head_d;
      srdy_q <= srdy_d;
      fc_n_q <= fc_n_d;
      ovf_q  <= ovf_d;
    end
  end

  // Storage needs no reset: entries are only read once the count marks them valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < channels; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= c_data;
      end
    end
  end

  assign c_fc_n = fc_n_q;
  assign p_srdy = srdy_q;
  assign p_data = head_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_dfc_vc_receiver.sv
// Randomized bench for dfc_vc_receiver: per-channel queue model checked every cycle on the
// falling clock edge.
module tb_dfc_vc_receiver;

  localparam int unsigned W   = 8;
  localparam int unsigned D   = 8;
  localparam int unsigned CH  = 2;
  localparam int unsigned THR = 2;

  logic              clk;
  logic              reset_n;
  logic              c_vld;
  logic [0:0]        c_vc;
  logic [W-1:0]      c_data;
  logic [CH-1:0]     c_fc_n;
  logic [CH-1:0]     p_srdy;
  logic [CH-1:0]     p_drdy;
  logic [CH*W-1:0]   p_data;
  logic [CH-1:0]     ovf;

  int checks;
  int errors;

  // Reference model: what each channel holds, head first, and its sticky overflow.
  logic [W-1:0] mq [CH][$];
  bit           movf [CH];
  logic [CH-1:0] fc_d1, fc_d2;
  int           ovf_events;

  dfc_vc_receiver #(
    .width    (W),
    .depth    (D),
    .channels (CH),
    .threshold(THR)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .c_vld  (c_vld),
    .c_vc   (c_vc),
    .c_data (c_data),
    .c_fc_n (c_fc_n),
    .p_srdy (p_srdy),
    .p_drdy (p_drdy),
    .p_data (p_data),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < CH; c++) begin
      mq[c].delete();
      movf[c] = 1'b0;
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < CH; c++) begin
      int sz;
      sz = mq[c].size();
      check_eq($sformatf("srdy%0d", c), 32'(p_srdy[c]), 32'(sz > 0));
      check_eq($sformatf("fc_n%0d", c), 32'(c_fc_n[c]), 32'((D - sz) > THR));
      check_eq($sformatf("ovf%0d", c), 32'(ovf[c]), 32'(movf[c]));
      if (sz > 0) check_eq($sformatf("data%0d", c), 32'(p_data[c*W +: W]), 32'(mq[c][0]));
    end
  endtask

  // Apply the edge that is about to happen to the model.
  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      bit do_pop, hit;
      do_pop = (mq[c].size() > 0) && p_drdy[c];
      hit    = c_vld && (int'(c_vc) == c);
      if (do_pop) void'(mq[c].pop_front());
      if (hit) begin
        if (mq[c].size() < D) mq[c].push_back(c_data);
        else begin
          movf[c] = 1'b1;
          ovf_events++;
        end
      end
    end
  endtask

  // One cycle: compare at the falling edge, then drive the next beat.
  // pv/pd are percent probabilities of vld and per-channel drdy; obey honours fc_n delayed 2.
  task automatic cycle(input int pv, input int pd0, input int pd1, input bit obey);
    @(negedge clk);
    compare_all();
    fc_d2 = fc_d1;
    fc_d1 = c_fc_n;
    c_vc   = 1'($urandom_range(0, 1));
    c_data = 8'($urandom);
    c_vld  = ($urandom_range(0, 99) < pv);
    if (obey && !fc_d2[c_vc]) c_vld = 1'b0;
    p_drdy[0] = ($urandom_range(0, 99) < pd0);
    p_drdy[1] = ($urandom_range(0, 99) < pd1);
    model_step();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    ovf_events = 0;
    reset_n    = 1'b0;
    c_vld      = 1'b0;
    c_vc       = '0;
    c_data     = '0;
    p_drdy     = '0;
    fc_d1      = '1;
    fc_d2      = '1;
    model_clear();

    repeat (2) @(negedge clk);
    check_eq("rst_data", p_data, 32'h0);
    check_eq("rst_srdy", 32'(p_srdy), 32'h0);
    check_eq("rst_fc_n", 32'(c_fc_n), 32'h3);
    reset_n = 1'b1;

    // Idle after reset.
    repeat (10) cycle(0, 100, 100, 1'b0);
    // Light traffic, mostly draining.
    repeat (300) cycle(50, 80, 80, 1'b0);
    // Sender respecting delayed flow control while consumers stall often: no overflow allowed.
    repeat (300) cycle(90, 20, 40, 1'b1);
    check_eq("no_ovf_fc", 32'(ovf), 32'h0);
    // Heavy traffic ignoring flow control, slow consumers: overflow paths.
    repeat (300) cycle(95, 15, 90, 1'b0);

    // Reset in the middle of a burst.
    repeat (20) cycle(95, 10, 10, 1'b0);
    @(negedge clk);
    compare_all();
    reset_n = 1'b0;
    c_vld   = 1'b0;
    #1;
    check_eq("midrst_srdy", 32'(p_srdy), 32'h0);
    check_eq("midrst_ovf", 32'(ovf), 32'h0);
    check_eq("midrst_fc_n", 32'(c_fc_n), 32'h3);
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    fc_d1   = '1;
    fc_d2   = '1;
    p_drdy  = '1;
    model_step();
    repeat (10) cycle(0, 100, 100, 1'b0);
    repeat (300) cycle(70, 50, 100, 1'b0);
    // Drain everything.
    repeat (30) cycle(0, 100, 100, 1'b0);
    @(negedge clk);
    compare_all();

    if (ovf_events == 0) check_eq("ovf_exercised", 32'(ovf_events), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
